decoder_rr_arbiter: RTL
=======================

// Module: decoder_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8-way one-hot select resource among 8 requesters.
//  The registered 3-bit grant index is decoded 3-to-8, gated by an enable, into a one-hot grant vector.
//  It sits in front of any 8-target datapath driven by the 3-to-8 decoder.
//  It sequences ownership with a request/done handshake and a hold-time watchdog.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one grant may be held (>=2); hold counter width = $clog2(MAX_HOLD)
// PORTS
//  clk       in   1  single clock, all state updates on rising edge
//  rst       in   1  synchronous, active-high reset
//  e         in   1  arbiter enable; 0 = no new grants, and any current grant is released
//  req       in   8  request vector, bit i = requester i
//  done      in   1  current owner finished; sampled only in GRANT
//  gnt       out  8  one-hot grant; always == gnt_vld ? (8'b1 << gnt_idx) : 8'h00
//  gnt_idx   out  3  index of current owner
//  gnt_vld   out  1  a grant is active
//  timeout   out  1  one-cycle pulse: previous grant was force-released by the watchdog
// BEHAVIOUR
//  - All outputs and state are registered. gnt is a pure decode of the gnt_idx/gnt_vld registers, with no req path.
//  - Reset (rst=1 at an edge): state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0.
//    This holds even mid-grant; req, done and e are ignored while rst=1.
//  - States: IDLE, GRANT.
//  - IDLE: if e=1 and |req, pick the first set bit i scanning ptr, ptr+1, ..., ptr+7 (mod 8).
//    Next edge: state=GRANT, gnt_idx=i, gnt_vld=1, hold_cnt=0. Latency is 1 cycle from sampled req to gnt.
//    If e=0 or req=0, stay in IDLE with outputs 0.
//  - GRANT: each cycle without a release, hold_cnt <= hold_cnt+1. Release conditions, evaluated in priority order:
//    1. e=0
//    2. done=1
//    3. req[gnt_idx]=0
//    4. hold_cnt==MAX_HOLD-1 (watchdog)
//  - On release, at the next edge: state=IDLE, gnt_vld=0 (gnt=0), ptr=gnt_idx+1 (3-bit wrap, 7->0), hold_cnt=0.
//    gnt_idx keeps its last value. timeout=1 for that one cycle only if condition 4 was the sole cause; otherwise timeout=0.
//  - Grant duration is therefore at most MAX_HOLD cycles.
//  - There is always at least one IDLE cycle between consecutive grants, and no back-to-back grants.
//  - Simultaneous events:
//    - done together with watchdog expiry is a normal release, timeout=0.
//    - Requests changing on other bits during GRANT have no effect until IDLE.
//  - Fairness: a continuously requesting agent is granted within 8 grants. The last owner has lowest priority next round.
//  - Pointer wrap: ptr=7 searches 7,0,1,...,6.
//  - If a requester re-requests immediately after timeout, it is granted again only if no other req bit is set.
// TESTING
//  1. rst=1 for 2 cycles with req=8'hFF, e=1 -> gnt=8'h00, gnt_vld=0, timeout=0. After rst=0, the first grant is idx 0 (gnt=8'h01) one cycle later.
//  2. e=1, req=8'h04 -> next cycle gnt=8'h04, gnt_idx=2. Drop req[2] -> next cycle gnt=8'h00, and a following req=8'h0C grants idx 3 (ptr=3).
//  3. req=8'hFF held, done pulsed in each grant's 2nd cycle -> grant order idx 0,1,2,...,7,0. Each grant lasts 2 cycles, each followed by 1 idle cycle.
//  4. Wrap: after a grant to idx 6 is released, req=8'h81 -> grant idx 7 (gnt=8'h80), then after release grant idx 0 (gnt=8'h01).
//  5. MAX_HOLD=16, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 16 cycles, then gnt=8'h00 with timeout=1 for 1 cycle, then idx 4 is re-granted. Repeat with req=8'h30 -> idx 5 granted after the timeout.
//  6. Mid-grant controls, from a grant with req=8'hFF:
//     - e=0 -> gnt=8'h00 next cycle, timeout=0, no new grant while e=0.
//     - rst=1 -> all outputs 0 at next edge, ptr=0.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 3-to-8 decoded select.
// The registered grant index drives a one-hot grant, released by done, drop, disable or watchdog.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [2:0]    idx_n;
  logic          vld_n;
  logic          to_n;
  logic [2:0]    pick;
  logic          found;
  logic          expired;
  logic          release_now;

  // First requester at or after ptr, wrapping through the 3-bit index space.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (!found && req[ptr + 3'(k)]) begin
        pick  = ptr + 3'(k);
        found = 1'b1;
      end
    end
  end

  assign expired     = (hold_cnt == HW'(MAX_HOLD - 1));
  assign release_now = !e || done || !req[gnt_idx] || expired;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    idx_n   = gnt_idx;
    vld_n   = gnt_vld;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (e && found) begin
          state_n = GRANT;
          idx_n   = pick;
          vld_n   = 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = IDLE;
          vld_n   = 1'b0;
          ptr_n   = gnt_idx + 3'd1;
          hold_n  = '0;
          // Only a watchdog expiry with no other release cause is reported.
          to_n    = e && !done && req[gnt_idx] && expired;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt_idx  <= idx_n;
      gnt_vld  <= vld_n;
      timeout  <= to_n;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt = 8'b1 << gnt_idx;
  end

endmodule
